// File: rtl/myc64_bus_pkg.sv
// Shared bus definitions: RAM owner encoding, slot phase constants, EXT queue entry.
package myc64_bus_pkg;

  typedef enum logic [1:0] {
    OWN_VIC = 2'd0,
    OWN_CPU = 2'd1,
    OWN_EXT = 2'd2
  } owner_e;

  localparam logic [2:0] SLOT_PH1 = 3'd0;
  localparam logic [2:0] SLOT_PH2 = 3'd4;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } ext_req_t;

endpackage

// File: rtl/ext_fifo.sv
// Small synchronous FIFO for external loader requests; depth 2**AW.
module ext_fifo
  import myc64_bus_pkg::*;
#(
  parameter int AW = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  ext_req_t data_i,
  input  logic     pop_i,
  output ext_req_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  ext_req_t    mem_q [0:(1<<AW)-1];
  logic        push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // A push into a full queue is legal when the head leaves in the same clk.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/bus_slot_sched.sv
// Bus slot scheduler: splits each 8-clk bus cycle into VIC and CPU/EXT halves.
// Optional EXT read support is enabled by defining MYC64_EXT_READ_EN.
module bus_slot_sched
  import myc64_bus_pkg::*;
#(
  parameter logic [2:0] CNTR_RESET  = 3'b101,
  parameter int         EXT_FIFO_AW = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_ph1_en,
  output logic        o_ph2_en,
  output logic        o_vic_slot,
  input  logic [15:0] i_vic_addr,
  input  logic        i_vic_bm,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_we,
  input  logic [7:0]  i_cpu_do,
  input  logic        i_ext_valid,
  input  logic [15:0] i_ext_addr,
  input  logic [7:0]  i_ext_data,
  output logic        o_ext_ready,
  output logic [15:0] o_ram_addr,
  output logic        o_ram_we,
  output logic [7:0]  o_ram_di,
  output logic        o_cpu_rdy,
  output logic [1:0]  o_owner
`ifdef MYC64_EXT_READ_EN
  ,
  input  logic        i_ext_we,
  input  logic [7:0]  i_ram_do,
  output logic [7:0]  o_ext_rdata,
  output logic        o_ext_rvalid
`endif
);

  logic [2:0] cntr_q, cntr_d;
  logic       vic_slot_q, vic_slot_d;
  owner_e     owner_q, owner_d, decision;
  logic       fair_q, fair_d;
  logic       ph1, ph2, push, pop, fifo_full, fifo_empty, ram_we;
  ext_req_t   push_req, head;

  assign ph1 = (cntr_q == SLOT_PH1);
  assign ph2 = (cntr_q == SLOT_PH2);

  // EXT only wins while the fair flag says the CPU had the previous half.
  always_comb begin
    if (!i_vic_bm)                   decision = OWN_VIC;
    else if (!fifo_empty && !fair_q) decision = OWN_EXT;
    else                             decision = OWN_CPU;
  end

  always_comb begin
    cntr_d     = cntr_q + 3'd1;
    vic_slot_d = vic_slot_q;
    owner_d    = owner_q;
    fair_d     = fair_q;
    if (ph1) begin
      vic_slot_d = 1'b0;
      owner_d    = decision;
      if (decision == OWN_EXT)      fair_d = 1'b1;
      else if (decision == OWN_CPU) fair_d = 1'b0;
    end
    if (ph2) begin
      vic_slot_d = 1'b1;
      owner_d    = OWN_VIC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cntr_q     <= CNTR_RESET;
      vic_slot_q <= 1'b1;
      owner_q    <= OWN_VIC;
      fair_q     <= 1'b0;
    end else begin
      cntr_q     <= cntr_d;
      vic_slot_q <= vic_slot_d;
      owner_q    <= owner_d;
      fair_q     <= fair_d;
    end
  end

  assign pop         = ph2 && (owner_q == OWN_EXT);
  assign o_ext_ready = !fifo_full || pop;
  assign push        = i_ext_valid && o_ext_ready;

  always_comb begin
    push_req.addr = i_ext_addr;
    push_req.data = i_ext_data;
`ifdef MYC64_EXT_READ_EN
    push_req.we   = i_ext_we;
`else
    push_req.we   = 1'b1;
`endif
  end

  ext_fifo #(.AW(EXT_FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_req),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    o_ram_addr = i_vic_addr;
    o_ram_di   = 8'h00;
    ram_we     = 1'b0;
    case (owner_q)
      OWN_CPU: begin
        o_ram_addr = i_cpu_addr;
        o_ram_di   = i_cpu_do;
        ram_we     = i_cpu_we;
      end
      OWN_EXT: begin
        o_ram_addr = head.addr;
        o_ram_di   = head.data;
        ram_we     = head.we;
      end
      default: ;
    endcase
  end

  // Reset kills an in-flight write immediately rather than at the next edge.
  assign o_ram_we   = ram_we && !rst;
  assign o_cpu_rdy  = ph1 && (decision == OWN_CPU);
  assign o_ph1_en   = ph1;
  assign o_ph2_en   = ph2;
  assign o_vic_slot = vic_slot_q;
  assign o_owner    = owner_q;

`ifdef MYC64_EXT_READ_EN
  logic [7:0] rdata_q, rdata_d;
  logic       rvalid_q, rvalid_d;

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (pop && !head.we) begin
      rdata_d  = i_ram_do;
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign o_ext_rdata  = rdata_q;
  assign o_ext_rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_bus_slot_sched.sv
// Directed bench for bus_slot_sched: phase timing, ownership, fairness, FIFO and reset.
module tb_bus_slot_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_ph1_en, o_ph2_en, o_vic_slot;
  logic [15:0] i_vic_addr;
  logic        i_vic_bm;
  logic [15:0] i_cpu_addr;
  logic        i_cpu_we;
  logic [7:0]  i_cpu_do;
  logic        i_ext_valid;
  logic [15:0] i_ext_addr;
  logic [7:0]  i_ext_data;
  logic        o_ext_ready;
  logic [15:0] o_ram_addr;
  logic        o_ram_we;
  logic [7:0]  o_ram_di;
  logic        o_cpu_rdy;
  logic [1:0]  o_owner;
`ifdef MYC64_EXT_READ_EN
  logic        i_ext_we;
  logic [7:0]  i_ram_do;
  logic [7:0]  o_ext_rdata;
  logic        o_ext_rvalid;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = -1;

  always #5 clk = ~clk;

  bus_slot_sched dut (
    .clk         (clk),
    .rst         (rst),
    .o_ph1_en    (o_ph1_en),
    .o_ph2_en    (o_ph2_en),
    .o_vic_slot  (o_vic_slot),
    .i_vic_addr  (i_vic_addr),
    .i_vic_bm    (i_vic_bm),
    .i_cpu_addr  (i_cpu_addr),
    .i_cpu_we    (i_cpu_we),
    .i_cpu_do    (i_cpu_do),
    .i_ext_valid (i_ext_valid),
    .i_ext_addr  (i_ext_addr),
    .i_ext_data  (i_ext_data),
    .o_ext_ready (o_ext_ready),
    .o_ram_addr  (o_ram_addr),
    .o_ram_we    (o_ram_we),
    .o_ram_di    (o_ram_di),
    .o_cpu_rdy   (o_cpu_rdy),
    .o_owner     (o_owner)
`ifdef MYC64_EXT_READ_EN
    ,
    .i_ext_we     (i_ext_we),
    .i_ram_do     (i_ram_do),
    .o_ext_rdata  (o_ext_rdata),
    .o_ext_rvalid (o_ext_rvalid)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @clk%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int p;
    rst         = 1'b1;
    i_vic_addr  = 16'h2000;
    i_vic_bm    = 1'b1;
    i_cpu_addr  = 16'hBEEF;
    i_cpu_we    = 1'b0;
    i_cpu_do    = 8'h77;
    i_ext_valid = 1'b0;
    i_ext_addr  = 16'h0000;
    i_ext_data  = 8'h00;
`ifdef MYC64_EXT_READ_EN
    i_ext_we    = 1'b1;
    i_ram_do    = 8'h5A;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and idle phase timing: ph1 at 3,11,19; ph2 at 7,15.
    step();
    chk("rst_ready", o_ext_ready, 1);
    chk("rst_we", o_ram_we, 0);
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) step();
      #1;
      p = k % 8;
      chk("idle_ph1", o_ph1_en, (p == 3));
      chk("idle_ph2", o_ph2_en, (p == 7));
      chk("idle_vic", o_vic_slot, !(p >= 4));
      chk("idle_owner", o_owner, (p >= 4) ? 1 : 0);
      chk("idle_rdy", o_cpu_rdy, (p == 3));
      chk("idle_we", o_ram_we, 0);
    end

    // VIC steals the CPU half for one ph1 cycle.
    goto(27);
    i_vic_bm = 1'b0; i_cpu_we = 1'b1; i_vic_addr = 16'h1234;
    #1 chk("bm_ph1", o_ph1_en, 1);
    chk("bm_rdy", o_cpu_rdy, 0);
    step(); i_vic_bm = 1'b1;
    #1 chk("bm_owner", o_owner, 0);
    chk("bm_we", o_ram_we, 0);
    chk("bm_addr", o_ram_addr, 16'h1234);
    chk("bm_vic", o_vic_slot, 0);

    goto(35); #1 chk("cpu_rdy", o_cpu_rdy, 1);
    step(); #1 chk("cpu_owner", o_owner, 1);
    chk("cpu_we", o_ram_we, 1);
    chk("cpu_addr", o_ram_addr, 16'hBEEF);
    chk("cpu_di", o_ram_di, 8'h77);

    // Two EXT pushes against a contending CPU: EXT, CPU, EXT, CPU.
    step();
    i_ext_valid = 1'b1; i_ext_addr = 16'h0400; i_ext_data = 8'h41;
    #1 chk("push1_ready", o_ext_ready, 1);
    step();
    i_ext_addr = 16'h0401; i_ext_data = 8'h42;
    #1 chk("push2_ready", o_ext_ready, 1);
    step();
    i_ext_valid = 1'b0;
    #1 chk("full_ready", o_ext_ready, 0);
    goto(43); #1 chk("ext1_rdy", o_cpu_rdy, 0);
    step(); #1 chk("ext1_owner", o_owner, 2);
    chk("ext1_addr", o_ram_addr, 16'h0400);
    chk("ext1_di", o_ram_di, 8'h41);
    chk("ext1_we", o_ram_we, 1);
    chk("ext1_ready", o_ext_ready, 0);
    goto(47); #1 chk("pop_ready", o_ext_ready, 1);
    goto(51); #1 chk("fair_cpu_rdy", o_cpu_rdy, 1);
    step(); #1 chk("fair_cpu_owner", o_owner, 1);
    goto(59); #1 chk("ext2_rdy", o_cpu_rdy, 0);
    step(); #1 chk("ext2_owner", o_owner, 2);
    chk("ext2_addr", o_ram_addr, 16'h0401);
    chk("ext2_di", o_ram_di, 8'h42);
    chk("ext2_we", o_ram_we, 1);
    goto(67); #1 chk("empty_cpu_rdy", o_cpu_rdy, 1);

    // Full FIFO, push coinciding with the pop at ph2.
    step();
    i_ext_valid = 1'b1; i_ext_addr = 16'h0500; i_ext_data = 8'hA1;
    step();
    i_ext_addr = 16'h0501; i_ext_data = 8'hB2;
    step();
    i_ext_valid = 1'b0;
    #1 chk("fill_ready", o_ext_ready, 0);
    goto(75); #1 chk("a_rdy", o_cpu_rdy, 0);
    step(); #1 chk("a_addr", o_ram_addr, 16'h0500);
    chk("a_di", o_ram_di, 8'hA1);
    goto(79);
    i_ext_valid = 1'b1; i_ext_addr = 16'h0502; i_ext_data = 8'hC3;
    #1 chk("pp_ph2", o_ph2_en, 1);
    chk("pp_ready", o_ext_ready, 1);
    step(); i_ext_valid = 1'b0;
    #1 chk("pp_full", o_ext_ready, 0);
    goto(83); #1 chk("pp_cpu_rdy", o_cpu_rdy, 1);
    goto(92); #1 chk("b_owner", o_owner, 2);
    chk("b_addr", o_ram_addr, 16'h0501);
    chk("b_di", o_ram_di, 8'hB2);
    goto(96); #1 chk("b_pop_ready", o_ext_ready, 1);
    goto(99); #1 chk("pp_cpu2_rdy", o_cpu_rdy, 1);
    goto(108); #1 chk("c_owner", o_owner, 2);
    chk("c_addr", o_ram_addr, 16'h0502);
    chk("c_di", o_ram_di, 8'hC3);

    // Reset in the middle of an EXT half with one more entry queued.
    i_ext_valid = 1'b1; i_ext_addr = 16'h0503; i_ext_data = 8'hD4;
    step();
    i_ext_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    #1 chk("mrst_owner", o_owner, 0);
    chk("mrst_we", o_ram_we, 0);
    chk("mrst_ready", o_ext_ready, 1);
    chk("mrst_vic", o_vic_slot, 1);
    goto(113); #1 chk("mrst_ph1", o_ph1_en, 1);
    chk("mrst_cpu_rdy", o_cpu_rdy, 1);
    step(); #1 chk("mrst_cpu_owner", o_owner, 1);

`ifdef MYC64_EXT_READ_EN
    // EXT read of 0x1000 returns RAM data without writing.
    step();
    i_ext_valid = 1'b1; i_ext_addr = 16'h1000; i_ext_data = 8'h00; i_ext_we = 1'b0;
    step();
    i_ext_valid = 1'b0; i_ext_we = 1'b1;
    goto(121); #1 chk("rd_rdy", o_cpu_rdy, 0);
    step(); #1 chk("rd_owner", o_owner, 2);
    chk("rd_we", o_ram_we, 0);
    chk("rd_addr", o_ram_addr, 16'h1000);
    chk("rd_rvalid_pre", o_ext_rvalid, 0);
    goto(126); #1 chk("rd_rvalid", o_ext_rvalid, 1);
    chk("rd_data", o_ext_rdata, 8'h5A);
    step(); #1 chk("rd_rvalid_end", o_ext_rvalid, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
